// File: rtl/lsu_stage_if.sv
// Handshake/bus bundle for the load/store stage: EXU input, memory request/response, WBU output.
// master is the stage itself; slave is whatever surrounds it.
interface lsu_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_exu_data;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [1:0]  in_mem_op;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic        out_err;

  modport master (
    input  in_valid, in_exu_data, in_store_data, in_rd, in_rd_wen, in_mem_op, in_size, in_unsigned,
           mem_req_ready, mem_rsp_valid, mem_rdata, out_ready,
    output in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
           out_valid, out_data, out_rd, out_rd_wen, out_err
  );
  modport slave (
    output in_valid, in_exu_data, in_store_data, in_rd, in_rd_wen, in_mem_op, in_size, in_unsigned,
           mem_req_ready, mem_rsp_valid, mem_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
           out_valid, out_data, out_rd, out_rd_wen, out_err
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: one instruction in flight, single-outstanding memory access with timeout,
// writeback packet carrying extended load data or the EXU result.
module lsu_stage #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic         clk,
  input logic         rst,
  lsu_stage_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, WB} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [1:0]    a_q, size_q;
  logic          uns_q, store_q, rd_wen_q;

  logic          accept, misal, bad, is_none, rsp_hit, tmo;
  logic [3:0]    strb;
  logic [31:0]   wd, sh, ld_data;

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign is_none = (bus.in_mem_op == 2'b00);
  assign rsp_hit = (state_q == WAIT_RSP) && bus.mem_rsp_valid;
  assign tmo     = (state_q == WAIT_RSP) && !bus.mem_rsp_valid && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    misal = 1'b0;
    strb  = 4'b1111;
    wd    = bus.in_store_data;
    case (bus.in_size)
      2'b00: begin
        strb = 4'b0001 << bus.in_exu_data[1:0];
        wd   = {4{bus.in_store_data[7:0]}};
      end
      2'b01: begin
        misal = bus.in_exu_data[0];
        strb  = 4'b0011 << bus.in_exu_data[1:0];
        wd    = {2{bus.in_store_data[15:0]}};
      end
      2'b10:   misal = |bus.in_exu_data[1:0];
      default: misal = 1'b1;
    endcase
  end

  // size is only meaningful for memory ops; a plain ALU op never errors
  assign bad = (bus.in_mem_op == 2'b11) || (!is_none && misal);

  // load lane select: shift the addressed byte/half down to bit 0, then extend
  always_comb begin
    sh      = bus.mem_rdata >> {a_q, 3'b000};
    ld_data = sh;
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   ld_data = uns_q ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.in_valid) state_d = (is_none || bad) ? WB : REQ;
      REQ:      if (bus.mem_req_ready) state_d = WAIT_RSP;
      WAIT_RSP: if (rsp_hit || tmo) state_d = WB;
      WB:       if (bus.out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // request valid comes straight from state so reset drops it without waiting for a clock
  assign bus.in_ready      = (state_q == IDLE);
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.out_valid     = (state_q == WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      a_q            <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      store_q        <= 1'b0;
      rd_wen_q       <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wen    <= 1'b0;
      bus.mem_wdata  <= '0;
      bus.mem_wstrb  <= '0;
      bus.out_data   <= '0;
      bus.out_rd     <= '0;
      bus.out_rd_wen <= 1'b0;
      bus.out_err    <= 1'b0;
    end else begin
      if (accept) begin
        a_q            <= bus.in_exu_data[1:0];
        size_q         <= bus.in_size;
        uns_q          <= bus.in_unsigned;
        store_q        <= (bus.in_mem_op == 2'b10);
        rd_wen_q       <= bus.in_rd_wen;
        bus.out_rd     <= bus.in_rd;
        bus.out_err    <= bad;
        bus.out_data   <= is_none ? bus.in_exu_data : 32'h0;
        bus.out_rd_wen <= is_none && bus.in_rd_wen;
        if (!is_none && !bad) begin
          bus.mem_addr  <= {bus.in_exu_data[31:2], 2'b00};
          bus.mem_wen   <= (bus.in_mem_op == 2'b10);
          bus.mem_wdata <= (bus.in_mem_op == 2'b10) ? wd : 32'h0;
          bus.mem_wstrb <= (bus.in_mem_op == 2'b10) ? strb : 4'b0000;
        end
      end
      if (state_q == REQ && bus.mem_req_ready) cnt_q <= '0;
      if (state_q == WAIT_RSP) begin
        if (rsp_hit) begin
          bus.out_data   <= store_q ? 32'h0 : ld_data;
          bus.out_rd_wen <= !store_q && rd_wen_q;
          bus.out_err    <= 1'b0;
        end else if (tmo) begin
          bus.out_data   <= 32'h0;
          bus.out_rd_wen <= 1'b0;
          bus.out_err    <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// Randomized + directed bench for lsu_stage against a packet-level reference model.
module tb_lsu_stage;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  lsu_stage_if bus ();
  lsu_stage #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [39:0] outv();
    return {bus.out_valid, bus.out_data, bus.out_rd, bus.out_rd_wen, bus.out_err};
  endfunction

  function automatic logic [69:0] memv(input logic st);
    return {bus.mem_req_valid, bus.mem_addr, bus.mem_wen, st ? bus.mem_wdata : 32'h0, bus.mem_wstrb};
  endfunction

  // One full instruction: issue, play memory, stall/accept writeback, compare with model.
  task automatic run_txn(input logic [31:0] exu, sd, rdata, input logic [4:0] rd, input logic wen,
                         input logic [1:0] op, size, input logic uns,
                         input int req_stall, rsp_delay, out_stall, input string tag);
    logic [1:0]  a;
    logic        illegal, mem, st;
    logic [31:0] sh, e_data, e_wd;
    logic [3:0]  e_strb;
    logic        e_wen, e_err;
    logic [69:0] e_mem;
    logic [39:0] e_out, held;
    int          k;
    a       = exu[1:0];
    st      = (op == 2'd2);
    illegal = (op == 2'd3) || (op != 2'd0 && (size == 2'd3 || (size == 2'd1 && a[0]) || (size == 2'd2 && a != 2'd0)));
    mem     = (op != 2'd0) && !illegal;
    e_strb  = (size == 2'd2) ? 4'hF : (size == 2'd1 ? 4'(3 << a) : 4'(1 << a));
    e_wd    = (size == 2'd2) ? sd : (size == 2'd1 ? sd[15:0] * 32'h00010001 : sd[7:0] * 32'h01010101);
    e_mem   = {1'b1, exu & ~32'h3, st, st ? e_wd : 32'h0, st ? e_strb : 4'h0};
    sh      = rdata >> (8 * a);
    if (op == 2'd0)              begin e_data = exu; e_wen = wen; e_err = 1'b0; end
    else if (illegal)            begin e_data = 0;   e_wen = 0;   e_err = 1'b1; end
    else if (rsp_delay > TMO - 1) begin e_data = 0;  e_wen = 0;   e_err = 1'b1; end
    else if (st)                 begin e_data = 0;   e_wen = 0;   e_err = 1'b0; end
    else begin
      e_wen = wen; e_err = 1'b0;
      case (size)
        2'd0:    e_data = uns ? sh % 256   : (sh[7]  ? {24'hFFFFFF, sh[7:0]}  : sh % 256);
        2'd1:    e_data = uns ? sh % 65536 : (sh[15] ? {16'hFFFF, sh[15:0]}   : sh % 65536);
        default: e_data = rdata;
      endcase
    end
    e_out = {1'b1, e_data, rd, e_wen, e_err};

    @(negedge clk);
    chk({tag, ".in_ready"}, 96'(bus.in_ready), 96'(1));
    bus.in_valid = 1'b1; bus.in_exu_data = exu; bus.in_store_data = sd; bus.in_rd = rd;
    bus.in_rd_wen = wen; bus.in_mem_op = op; bus.in_size = size; bus.in_unsigned = uns;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_exu_data = $urandom; bus.in_store_data = $urandom;
    bus.in_rd = 5'($urandom); bus.in_mem_op = 2'($urandom); bus.in_size = 2'($urandom);
    if (mem) begin
      chk({tag, ".req"}, 96'(memv(st)), 96'(e_mem));
      chk({tag, ".req_noout"}, 96'(bus.out_valid), 96'(0));
      for (int i = 0; i < req_stall; i++) begin
        @(negedge clk);
        chk({tag, ".req_hold"}, 96'(memv(st)), 96'(e_mem));
      end
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      chk({tag, ".req_drop"}, 96'(bus.mem_req_valid), 96'(0));
      k = 0;
      while (!bus.out_valid && k < 20) begin
        bus.mem_rsp_valid = (k == rsp_delay);
        bus.mem_rdata     = (k == rsp_delay) ? rdata : $urandom;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        k++;
      end
      chk({tag, ".wait_cycles"}, 96'(k), 96'((rsp_delay <= TMO - 1) ? rsp_delay + 1 : TMO));
    end else begin
      chk({tag, ".noreq_wb"}, 96'({bus.mem_req_valid, bus.out_valid}), 96'(2'b01));
    end
    chk({tag, ".out"}, 96'(outv()), 96'(e_out));
    held = outv();
    for (int i = 0; i < out_stall; i++) begin
      bus.mem_rsp_valid = 1'($urandom);
      bus.mem_rdata     = $urandom;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      chk({tag, ".out_hold"}, 96'({bus.in_ready, outv()}), 96'({1'b0, held}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".done"}, 96'({bus.out_valid, bus.in_ready}), 96'(2'b01));
  endtask

  task automatic issue_load(input logic [31:0] addr);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_exu_data = addr; bus.in_rd = 5'd9; bus.in_rd_wen = 1'b1;
    bus.in_mem_op = 2'd1; bus.in_size = 2'd2; bus.in_unsigned = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] op, sz;
    bus.in_valid = 0; bus.in_exu_data = 0; bus.in_store_data = 0; bus.in_rd = 0; bus.in_rd_wen = 0;
    bus.in_mem_op = 0; bus.in_size = 0; bus.in_unsigned = 0; bus.mem_req_ready = 0;
    bus.mem_rsp_valid = 0; bus.mem_rdata = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset.state", 96'({bus.in_ready, bus.mem_req_valid, bus.mem_addr, bus.mem_wstrb, outv()}),
        96'({1'b1, 1'b0, 32'h0, 4'h0, 40'h0}));
    rst = 1'b0;

    run_txn(32'h12345678, 0, 0, 5'd5, 1, 2'd0, 2'd2, 0, 0, 0, 0, "alu");
    run_txn(32'h80000003, 0, 32'h80FF0000, 5'd7, 1, 2'd1, 2'd0, 0, 0, 1, 0, "ldb_s");
    run_txn(32'h80000003, 0, 32'h80FF0000, 5'd7, 1, 2'd1, 2'd0, 1, 1, 0, 0, "ldb_u");
    run_txn(32'h80000002, 32'h0000BEEF, 0, 5'd3, 1, 2'd2, 2'd1, 0, 3, 2, 0, "sth");
    run_txn(32'h80000001, 0, 0, 5'd4, 1, 2'd1, 2'd2, 0, 0, 0, 0, "ldw_mis");
    run_txn(32'h00000010, 0, 32'hCAFEF00D, 5'd6, 1, 2'd1, 2'd2, 0, 0, 9, 0, "tmo");
    run_txn(32'h00000010, 0, 32'hCAFEF00D, 5'd6, 1, 2'd1, 2'd2, 0, 0, 3, 0, "tmo_race");
    run_txn(32'h00000020, 0, 0, 5'd1, 1, 2'd3, 2'd2, 0, 0, 0, 5, "op11_bp");

    // async reset while a request is pending
    issue_load(32'h00000100);
    chk("rst.req_before", 96'(bus.mem_req_valid), 96'(1));
    rst = 1'b1;
    #1;
    chk("rst.req_async", 96'({bus.mem_req_valid, bus.in_ready, outv()}), 96'({1'b0, 1'b1, 40'h0}));
    @(negedge clk);
    rst = 1'b0;

    // reset in WAIT_RSP, then a stale response must be ignored
    issue_load(32'h00000200);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.wait_ignored", 96'({bus.in_ready, bus.mem_req_valid, bus.mem_addr, outv()}),
        96'({1'b1, 1'b0, 32'h0, 40'h0}));

    for (int t = 0; t < 150; t++) begin
      op = 2'($urandom_range(0, 9) < 4 ? 1 : ($urandom_range(0, 5) < 3 ? 2 : $urandom_range(0, 3)));
      sz = 2'($urandom_range(0, 3));
      if (op == 2'd0 && sz == 2'd3) sz = 2'd2;
      run_txn($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), op, sz, 1'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
